rr_grant_index_gen: RTL
=======================

# rr_grant_index_gen

Round-robin arbiter for 16 requesters that selects one winner and presents it as a 4-bit binary grant index with a valid/ready handshake. It sits directly upstream of the binary-to-one-hot encoder. `grant_idx` drives that encoder's `binary_input`, and the encoder's 16-bit one-hot output becomes the per-requester grant vector. Fairness is enforced by a rotating priority pointer that advances past each accepted winner.

## Interface
- `N_REQ`, default 16: number of requesters; fixed at 16 to match the one-hot encoder width.
- `IDX_W`, default 4: grant index width, equal to log2(`N_REQ`).
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_i`  in  16: request vector; bit k = requester k wants service; level-sensitive.
- `grant_idx`  out  4: binary index of the current winner; connects to the encoder `binary_input`.
- `grant_valid`  out  1: `grant_idx` holds a valid offer.
- `grant_ready`  in  1: consumer accepts the offer when `grant_valid && grant_ready`.
- `busy`  out  1: high while in OFFER.
- `grant_count`  out  16: saturating count of accepted grants; present only with `ARB_GRANT_COUNT_EN`.

## Operation
- FSM states: IDLE, OFFER.
- IDLE, `req_i` == 0: remain in IDLE with `grant_valid` = 0.
- IDLE, `req_i` != 0:
  - Pick the first set bit at or above `ptr`, wrapping 15 -> 0.
  - Register the winner into `grant_idx`, set `grant_valid` = 1, go to OFFER.
- OFFER:
  - Hold `grant_idx` and `grant_valid` stable, whatever `req_i` does.
  - The grant is sticky: a winner that deasserts its request is still offered.
- OFFER with `grant_valid && grant_ready`:
  - `ptr` <= `grant_idx` + 1, mod 16 (15 wraps to 0).
  - `grant_valid` <= 0, state <= IDLE.
- Index arithmetic is 4-bit unsigned and wraps naturally.
- Single requester k: wins on every arbitration regardless of `ptr`.
- `grant_ready` while in IDLE: ignored.
- `rst` has priority over every other event, including mid-offer: the pending offer is dropped with no acceptance counted.

## Timing
- Reset values:
  - state = IDLE
  - `ptr` = 0
  - `grant_idx` = 0
  - `grant_valid` = 0
  - `busy` = 0
  - `grant_count` = 0
- Latency: `req_i` sampled in cycle N gives `grant_valid` = 1 in cycle N+1.
- Handshake rules:
  - Acceptance completes in the cycle `grant_ready` is sampled high.
  - `grant_valid` is low in the following cycle.
  - `grant_ready` may be held high permanently.
  - `grant_valid` never depends combinationally on `grant_ready`.
- Throughput: at most one grant every 2 cycles; IDLE is a mandatory one-cycle bubble.
- `req_i` changes during OFFER take effect only at the next IDLE arbitration.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `ARB_GRANT_COUNT_EN` defined:
  - Adds the `grant_count` port and a 16-bit register.
  - Increments by 1 on each accepted handshake.
  - Saturates at 16'hFFFF.
  - Cleared by `rst`.
- `ARB_GRANT_COUNT_EN` undefined: neither the port nor the register exists; all other behaviour is identical.

## Structure
- Package `arb_pkg` holds:
  - `N_REQ` = 16 and `IDX_W` = 4.
  - The `arb_state_t` enum {IDLE, OFFER}.
  - The counter saturation constant.
- Sub-module `rr_priority_pick`: purely combinational masked priority finder.
  - Inputs: `req` [15:0], `ptr` [3:0].
  - Outputs: `idx` [3:0], `any`.
  - Method: two-pass search, first over bits >= `ptr`, then over the full vector.
- The top level instantiates one `rr_priority_pick` and owns the FSM, `ptr` and the optional counter.

## Test plan
- Reset, then `req_i` = 16'h0000 for 5 cycles -> `grant_valid` stays 0, `grant_idx` = 0.
- `req_i` = 16'h0001 with `grant_ready` = 1 held -> alternating cycles give `grant_valid` = 1, `grant_idx` = 0; encoder output = 16'h0001.
- `req_i` = 16'h8421 held with `grant_ready` = 1 -> grant sequence 0, 5, 10, 15, 0.
- Offer `grant_idx` = 3, hold `grant_ready` = 0 for 4 cycles, drop `req_i`[3] -> `grant_idx` stays 3 and `grant_valid` stays 1 until accepted.
- Accept `grant_idx` = 15 with `req_i` = 16'h8001 -> next grant is 0 (`ptr` wrap).
- Assert `rst` mid-OFFER -> next cycle `grant_valid` = 0 and `ptr` = 0.
  - With `ARB_GRANT_COUNT_EN`: `grant_count` = 0.
  - Separately, 3 accepts from reset -> `grant_count` = 3.

Source files
------------

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and state type for the round-robin grant index generator
// Contents:
//   N_REQ           number of requesters (16, matches the downstream one-hot encoder)
//   IDX_W           grant index width, log2(N_REQ)
//   arb_state_t     arbiter FSM states {IDLE, OFFER}
//   GRANT_COUNT_MAX saturation value of the optional accepted-grant counter
package arb_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

  localparam logic [15:0] GRANT_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin priority finder
// Ports:
//   req [N_REQ-1:0] in   request vector
//   ptr [IDX_W-1:0] in   highest-priority position for this search
//   idx [IDX_W-1:0] out  first set request at or above ptr, wrapping to bit 0
//   any             out  at least one request is set (idx is meaningful only then)
module rr_priority_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [N_REQ-1:0] mask;
  logic [N_REQ-1:0] masked;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;
  logic             hi_any;

  // Bits at or above ptr form the first search window; if that window is
  // empty the wrapped-around winner is simply the lowest set bit overall.
  assign mask   = {N_REQ{1'b1}} << ptr;
  assign masked = req & mask;
  assign hi_any = |masked;
  assign any    = |req;

  // Descending scans so the last assignment is the lowest set bit.
  always_comb begin
    hi_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (masked[i]) begin
        hi_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    lo_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = IDX_W'(i);
      end
    end
  end

  assign idx = hi_any ? hi_idx : lo_idx;

endmodule

// File: rtl/rr_grant_index_gen.sv
// rtl/rr_grant_index_gen.sv - round-robin arbiter presenting the winner as a binary grant index
// Optional feature macro: ARB_GRANT_COUNT_EN (adds the grant_count port and counter)
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   synchronous active-high reset
//   req_i [15:0] in   level-sensitive request vector
//   grant_idx[3:0] out registered winner index (feeds encoder binary_input)
//   grant_valid  out  grant_idx holds an offer
//   grant_ready  in   consumer accepts when grant_valid && grant_ready
//   busy         out  high while in OFFER
//   grant_count[15:0] out saturating accepted-grant count (ARB_GRANT_COUNT_EN only)
module rr_grant_index_gen
  import arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  input  logic             grant_ready,
  output logic             busy
`ifdef ARB_GRANT_COUNT_EN
  ,
  output logic [15:0]      grant_count
`endif
);

  arb_state_t       state;
  arb_state_t       state_nx;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_nx;
  logic [IDX_W-1:0] idx_nx;
  logic             valid_nx;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             accept;

  rr_priority_pick u_pick (
    .req (req_i),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign accept = (state == OFFER) && grant_valid && grant_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      ptr         <= ptr_nx;
      grant_idx   <= idx_nx;
      grant_valid <= valid_nx;
      busy        <= (state_nx == OFFER);
    end
  end

  // The request vector is only looked at in IDLE, so the offer stays frozen
  // (and sticky) no matter how req_i moves while it is outstanding.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    idx_nx   = grant_idx;
    valid_nx = grant_valid;
    case (state)
      IDLE: begin
        if (pick_any) begin
          idx_nx   = pick_idx;
          valid_nx = 1'b1;
          state_nx = OFFER;
        end
      end
      OFFER: begin
        if (accept) begin
          ptr_nx   = grant_idx + IDX_W'(1);
          valid_nx = 1'b0;
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        valid_nx = 1'b0;
      end
    endcase
  end

`ifdef ARB_GRANT_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_count <= '0;
    end else if (accept && (grant_count != GRANT_COUNT_MAX)) begin
      grant_count <= grant_count + 16'd1;
    end
  end
`endif

endmodule
